// File: rtl/acquire_q_if.sv
// rtl/acquire_q_if.sv - FPE array request side and data-memory write side of acquire_q
interface acquire_q_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int REG_W  = 8,
  parameter int CPU_W  = 5
);
  logic                     first_ac;
  logic                     spec_en;
  logic [LANES-1:0]         lane_mask;
  logic [REG_W-1:0]         delay_r;
  logic [CPU_W-1:0]         rd1_s;
  logic [DATA_W*LANES-1:0]  fpearray;
  logic [DATA_W*LANES-1:0]  todmem;
  logic [LANES-1:0]         dmemwe;
  logic [REG_W-1:0]         diff;
  logic [CPU_W-1:0]         rdst;
  logic                     done;
  logic                     full;
  logic                     ovf;
  logic [3:0]               stdbg;

  modport master (
    output first_ac, spec_en, lane_mask, delay_r, rd1_s, fpearray,
    input  todmem, dmemwe, diff, rdst, done, full, ovf, stdbg
  );

  modport slave (
    input  first_ac, spec_en, lane_mask, delay_r, rd1_s, fpearray,
    output todmem, dmemwe, diff, rdst, done, full, ovf, stdbg
  );
endinterface

// File: rtl/acquire_q.sv
// rtl/acquire_q.sv - multi-entry speculative store acquisition queue between FPE array and dmem
module acquire_q #(
  parameter int DATA_W   = 16,
  parameter int LANES    = 8,
  parameter int DEPTH    = 4,
  parameter int REG_W    = 8,
  parameter int CPU_W    = 5,
  parameter int DIFF_MAX = 15
) (
  input logic       clk,
  input logic       rst_n,
  acquire_q_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = DATA_W * LANES;

  logic [DEPTH-1:0] valid;
  logic [DW-1:0]    data_q [DEPTH];
  logic [LANES-1:0] mask_q [DEPTH];
  logic [CPU_W-1:0] tag_q  [DEPTH];
  logic [DEPTH-1:0] spec_q;
  logic [REG_W-1:0] cnt_q  [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [REG_W-1:0] diff_q;
  logic             ovf_q;

  logic             full, alloc, spec_wr, head_ok, mismatch, chk_wr, retire, fail, sacc, wr_en;
  logic [LANES-1:0] lane_diff, wr_mask;
  logic [REG_W-1:0] diff_nxt, load_val, load_cnt;

  always_comb begin
    full     = &valid;
    alloc    = bus.first_ac & ~full & rst_n;
    spec_wr  = alloc & bus.spec_en;
    head_ok  = valid[head] & (cnt_q[head] == '0);
    lane_diff = '0;
    for (int l = 0; l < LANES; l++)
      lane_diff[l] = bus.fpearray[l*DATA_W +: DATA_W] != data_q[head][l*DATA_W +: DATA_W];
    mismatch = |(lane_diff & mask_q[head]);
    fail     = head_ok & spec_q[head] & mismatch;
    sacc     = head_ok & spec_q[head] & ~mismatch;
    chk_wr   = head_ok & (~spec_q[head] | mismatch);
    // A check that needs the write port yields to a speculative allocation write.
    retire   = head_ok & ~(chk_wr & spec_wr);
    wr_en    = spec_wr | (retire & chk_wr);
    wr_mask  = '0;
    if (spec_wr)
      wr_mask = bus.lane_mask;
    else if (retire & chk_wr)
      wr_mask = mask_q[head];

    diff_nxt = diff_q;
    if (retire & fail & (diff_q > REG_W'(1)))
      diff_nxt = diff_q - REG_W'(1);
    else if (sacc & (diff_q < REG_W'(DIFF_MAX)) &
             (({1'b0, diff_q} + (REG_W+1)'(1)) < {1'b0, bus.delay_r}))
      diff_nxt = diff_q + REG_W'(1);

    // Counter holds cycles remaining after the first one, so a wait of W checks at t+W.
    load_val = bus.spec_en ? diff_q : bus.delay_r;
    load_cnt = (load_val == '0) ? '0 : load_val - REG_W'(1);
  end

  assign bus.todmem = wr_en ? bus.fpearray : '0;
  assign bus.dmemwe = wr_mask;
  assign bus.done   = retire;
  assign bus.rdst   = retire ? tag_q[head] : '0;
  assign bus.diff   = diff_q;
  assign bus.full   = full;
  assign bus.ovf    = ovf_q;
  assign bus.stdbg  = {fail, ovf_q, valid[head] & spec_q[head], |wr_mask};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      head   <= '0;
      tail   <= '0;
      diff_q <= REG_W'(1);
      ovf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        cnt_q[i] <= '0;
    end else begin
      if (bus.first_ac & full)
        ovf_q <= 1'b1;
      diff_q <= diff_nxt;
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc && tail == PW'(i))
          cnt_q[i] <= load_cnt;
        else if (valid[i] && cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - REG_W'(1);
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (alloc) begin
      data_q[tail] <= bus.fpearray;
      mask_q[tail] <= bus.lane_mask;
      tag_q[tail]  <= bus.rd1_s;
      spec_q[tail] <= bus.spec_en;
    end
  end
endmodule

// File: tb/tb_acquire_q.sv
// tb/tb_acquire_q.sv - randomized scoreboard bench for acquire_q
module tb_acquire_q;
  localparam int DATA_W = 16, LANES = 8, DEPTH = 4, REG_W = 8, CPU_W = 5, DIFF_MAX = 15;
  localparam int DW = DATA_W * LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acquire_q_if #(.DATA_W(DATA_W), .LANES(LANES), .REG_W(REG_W), .CPU_W(CPU_W)) bus ();

  acquire_q #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .REG_W(REG_W),
              .CPU_W(CPU_W), .DIFF_MAX(DIFF_MAX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [DW-1:0] data; logic [LANES-1:0] mask; logic [CPU_W-1:0] tag; bit spec; int due; } ent_t;
  typedef struct { int cyc; logic [DW-1:0] data; logic [LANES-1:0] we; } wr_t;
  typedef struct { int cyc; logic [CPU_W-1:0] tag; } dn_t;
  typedef struct { int diff; bit full; bit ovf; } st_t;

  ent_t mq[$];
  wr_t  wq[$];
  dn_t  dq[$];
  st_t  sq[$];
  int   m_diff = 1;
  bit   m_ovf = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  logic [REG_W-1:0] dly = 8;
  logic [DW-1:0]    arr_g = '0;
  logic [CPU_W-1:0] tag_n = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: entries carry an absolute due cycle; only the oldest one is ever examined.
  task automatic model_eval();
    bit alloc, spec_wr, mism, need_wr;
    logic [LANES-1:0] wmask;
    int w, new_diff;
    st_t s;
    s.diff = m_diff; s.full = (mq.size() == DEPTH); s.ovf = m_ovf;
    sq.push_back(s);
    wmask = '0;
    alloc = bus.first_ac && mq.size() < DEPTH;
    if (bus.first_ac && mq.size() == DEPTH) m_ovf = 1'b1;
    spec_wr = alloc && bus.spec_en;
    if (spec_wr) wmask = bus.lane_mask;
    w = bus.spec_en ? m_diff : int'(bus.delay_r);
    new_diff = m_diff;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mism = 1'b0;
      for (int l = 0; l < LANES; l++)
        if (mq[0].mask[l] && bus.fpearray[l*DATA_W +: DATA_W] != mq[0].data[l*DATA_W +: DATA_W])
          mism = 1'b1;
      need_wr = !mq[0].spec || mism;
      if (!(need_wr && spec_wr)) begin
        dq.push_back('{cyc, mq[0].tag});
        if (need_wr) wmask = mq[0].mask;
        if (mq[0].spec && mism && m_diff > 1) new_diff = m_diff - 1;
        if (mq[0].spec && !mism && m_diff < DIFF_MAX && m_diff + 1 < int'(bus.delay_r))
          new_diff = m_diff + 1;
        void'(mq.pop_front());
      end
    end
    if (wmask != '0) wq.push_back('{cyc, bus.fpearray, wmask});
    if (alloc) mq.push_back('{bus.fpearray, bus.lane_mask, bus.rd1_s, bus.spec_en, cyc + ((w < 1) ? 1 : w)});
    m_diff = new_diff;
  endtask

  always @(negedge clk) begin : mon
    wr_t w;
    dn_t d;
    st_t s;
    if (rst_n) begin
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("diff", DW'(bus.diff), DW'(s.diff));
        chk("full", DW'(bus.full), DW'(s.full));
        chk("ovf", DW'(bus.ovf), DW'(s.ovf));
      end
      if (bus.dmemwe != '0) begin
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: dmemwe=%0h at cycle %0d, required no write", bus.dmemwe, cyc);
        end else begin
          w = wq.pop_front();
          chk("write_cycle", DW'(cyc), DW'(w.cyc));
          chk("dmemwe", DW'(bus.dmemwe), DW'(w.we));
          chk("todmem", bus.todmem, w.data);
        end
      end else
        chk("todmem_idle", bus.todmem, '0);
      if (bus.done) begin
        if (dq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: rdst=%0h at cycle %0d, required no done", bus.rdst, cyc);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", DW'(cyc), DW'(d.cyc));
          chk("rdst", DW'(bus.rdst), DW'(d.tag));
        end
      end
    end
  end

  function automatic logic [DW-1:0] rand_arr();
    logic [DW-1:0] a;
    for (int l = 0; l < LANES; l++) a[l*DATA_W +: DATA_W] = DATA_W'($urandom);
    return a;
  endfunction

  task automatic poke_lane(int l);
    arr_g[l*DATA_W +: DATA_W] = arr_g[l*DATA_W +: DATA_W] ^ DATA_W'($urandom_range(1, 65535));
  endtask

  task automatic step(bit fa, bit sp, logic [LANES-1:0] m);
    @(posedge clk); #1;
    bus.first_ac = fa; bus.spec_en = sp; bus.lane_mask = m; bus.rd1_s = tag_n;
    bus.fpearray = arr_g; bus.delay_r = dly;
    if (fa) tag_n = tag_n + CPU_W'(1);
    model_eval();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'hFF);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bus.first_ac = 1'b0;
    mq.delete(); wq.delete(); dq.delete(); sq.delete();
    m_diff = 1; m_ovf = 1'b0;
    #1;
    chk("rst_todmem", bus.todmem, '0);
    chk("rst_dmemwe", DW'(bus.dmemwe), '0);
    chk("rst_done", DW'(bus.done), '0);
    chk("rst_rdst", DW'(bus.rdst), '0);
    chk("rst_diff", DW'(bus.diff), DW'(1));
    chk("rst_full", DW'(bus.full), '0);
    chk("rst_ovf", DW'(bus.ovf), '0);
    chk("rst_stdbg", DW'(bus.stdbg), '0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    model_eval();
  endtask

  initial begin
    bus.first_ac = 1'b0; bus.spec_en = 1'b0; bus.lane_mask = '0; bus.rd1_s = '0;
    bus.delay_r = dly; bus.fpearray = '0;
    arr_g = rand_arr();
    do_reset();
    idle(2);

    // Speculative match: diff 1 -> 2, then 2 -> 3
    dly = 8;
    step(1'b1, 1'b1, 8'hFF); idle(3);
    chk("diff_after_match", DW'(bus.diff), DW'(2));
    step(1'b1, 1'b1, 8'hFF); idle(4);
    chk("diff_after_match2", DW'(bus.diff), DW'(3));

    // Speculative fail on lane 2 until diff floors at 1
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 8'hFF);
      poke_lane(2); idle(6);
    end
    chk("diff_floor", DW'(bus.diff), DW'(1));

    // Masked compare ignores lane 6; then delay_r caps growth
    step(1'b1, 1'b1, 8'h0F);
    poke_lane(6); idle(4);
    chk("diff_masked_sacc", DW'(bus.diff), DW'(2));
    dly = 3;
    step(1'b1, 1'b1, 8'hFF); idle(4);
    chk("diff_capped", DW'(bus.diff), DW'(2));

    // Non-speculative single write after delay_r
    dly = 5;
    step(1'b1, 1'b0, 8'hFF);
    poke_lane(1); idle(7);
    chk("diff_nonspec", DW'(bus.diff), DW'(2));

    // Queue fill and overflow
    dly = 10;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'hFF);
    #3 chk("full_after_4", DW'(bus.full), DW'(1));
    idle(1);
    #3 chk("ovf_sticky", DW'(bus.ovf), DW'(1));
    chk("stdbg_ovf", DW'(bus.stdbg[2]), DW'(1));
    idle(16);

    // Fail check colliding with a speculative allocation is deferred
    dly = 8;
    step(1'b1, 1'b1, 8'hFF);
    poke_lane(3); idle(1);
    step(1'b1, 1'b1, 8'hFF);
    #3;
    chk("defer_done", DW'(bus.done), '0);
    chk("defer_fail", DW'(bus.stdbg[3]), DW'(1));
    chk("defer_alloc_we", DW'(bus.dmemwe), DW'(8'hFF));
    idle(8);

    // Reset with three entries pending
    dly = 10;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'hFF);
    idle(2);
    do_reset();
    idle(20);
    chk("post_rst_diff", DW'(bus.diff), DW'(1));

    // Randomized traffic with one reset mid-run
    for (int c = 0; c < 500; c++) begin
      if (c == 250) do_reset();
      if ($urandom_range(0, 7) == 0) dly = REG_W'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) poke_lane($urandom_range(0, LANES-1));
      step($urandom_range(0, 2) == 0, 1'($urandom), LANES'($urandom_range(1, 255)));
    end
    idle(40);

    chk("writes_drained", DW'(wq.size()), '0);
    chk("dones_drained", DW'(dq.size()), '0);
    chk("model_empty_full", DW'(bus.full), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/acquire_q.md
# acquire_q

Multi-entry, lane-parametrised successor of the single-shot store acquisition stage. Captures the FPE array output into a queue of up to DEPTH outstanding acquisitions. In speculative mode it writes each capture to data memory immediately, then re-samples after an adaptive wait `diff`: a mismatch rewrites memory and shortens `diff`; a match lengthens it. In non-speculative mode it performs a single write after `delay_r` cycles. It sits between the FPE array and the data-memory write port.

## Interface
- `DATA_W`, 16, bits per lane
- `LANES`, 8, lanes in array / dmem write-enable width
- `DEPTH`, 4, outstanding entries (power of 2, ≥2)
- `REG_W`, 8, width of `delay_r`, `diff`, counters
- `CPU_W`, 5, destination-register tag width
- `DIFF_MAX`, 15, upper bound of `diff`

Ports:
- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous, active-low reset
- `first_ac` in 1 — acquisition request, one cycle
- `spec_en` in 1 — 1 = speculative mode; sampled at `first_ac`, stored per entry
- `lane_mask` in LANES — lanes written/compared; sampled at `first_ac`
- `delay_r` in REG_W — settle delay of the array
- `rd1_s` in CPU_W — tag stored with the entry
- `fpearray` in DATA_W*LANES — live array output
- `todmem` out DATA_W*LANES — write data
- `dmemwe` out LANES — per-lane write enable
- `diff` out REG_W — current adaptive wait
- `rdst` out CPU_W — tag of the retiring entry, valid with `done`
- `done` out 1 — one-cycle pulse on retirement
- `full` out 1 — all DEPTH entries valid
- `ovf` out 1 — sticky; set by `first_ac` while `full`
- `stdbg` out 4 — {fail, ovf, head_spec, memwe}

## Operation
- Entry fields: valid, data (DATA_W*LANES), mask, tag, spec, wait counter (REG_W). Circular FIFO with head and tail pointers.
- Allocation (`first_ac` & !`full`):
  - Capture `fpearray`, `lane_mask`, `rd1_s`, `spec_en` at tail.
  - Load the counter with `diff` if `spec_en`=1, else with `delay_r`.
  - If `spec_en`=1, drive `todmem`=`fpearray` and `dmemwe`=`lane_mask` in this same cycle (initial write).
- `first_ac` & `full`: request dropped; no write; `ovf`←1.
- Counters of all valid entries decrement by 1 each cycle while non-zero, from the cycle after allocation. They saturate at 0.
- Head is eligible when valid, counter = 0, and not allocated this cycle. Only the head is ever checked, so retirement is strictly in order; younger expired entries wait.
- Eligible head, spec=1:
  - Masked compare of `fpearray` against the stored data. Unmasked lanes are ignored.
  - Mismatch (fail): `todmem`=`fpearray`, `dmemwe`=mask; if `diff`>1 then `diff`−1.
  - Match (sacc): no write; if `diff`<DIFF_MAX and `diff`+1<`delay_r` then `diff`+1.
- Eligible head, spec=0: unconditional write, `todmem`=`fpearray`, `dmemwe`=mask. `diff` is unchanged.
- Every eligible check retires the head: `done`=1, `rdst`=tag, head advances, valid cleared.
- Port conflict: a speculative allocation write has priority. An eligible check that would write in the same cycle is deferred, keeping the head and re-evaluating next cycle. A check that would not write (sacc) proceeds and may retire in that cycle.
- A non-speculative allocation does not use the port, so no conflict arises.
- Same-cycle allocate into a freed slot while the head retires is legal. `full` is computed after both updates.
- `dmemwe`=0 and `todmem`=0 whenever no write occurs.
- `memwe` = OR of `dmemwe`.

## Timing
- Reset (async, any time): all entries invalid, pointers 0, `diff`=1, `ovf`=0, all outputs 0. In-flight entries are discarded with no write.
- Speculative initial write: combinational in the `first_ac` cycle (0 latency).
- Check cycle (no contention, queue otherwise empty): allocation at cycle t, check at t+W, where W is the loaded counter value. A counter loaded with 0 checks at t+1.
- A `diff` update takes effect at the next clock edge. Entries capture `diff` at their own allocation.
- At most one retirement and one allocation per cycle.

## Test plan
- Speculative match: `diff`=1, `delay_r`=8, mask=0xFF, array stable. Expect: write at t; `done` at t+1 with no write; `diff`=2.
- Speculative fail: `diff`=3, array changes on lane 2 at t+1. Expect: rewrite at t+3 with new data, `dmemwe`=0xFF; `diff`=2. Repeat until `diff` floors at 1.
- Masked compare: mask=0x0F, only lane 6 changes. Expect: sacc, `dmemwe` 0 at check, `diff` increments. Then set `delay_r`=3 with `diff`=2 and expect `diff` to stay 2.
- Non-speculative: `spec_en`=0, `delay_r`=5. Expect: no write at t; single write of array value at t+5; `diff` unchanged.
- Queue: DEPTH=4, five `first_ac` on consecutive cycles. Expect: `full` after the 4th, `ovf`=1; retirement tags in order; a fail check coinciding with a new speculative `first_ac` defers one cycle.
- Reset mid-operation: assert `rst_n`=0 with 3 entries pending. Expect: all outputs 0, `diff`=1, no further writes or `done`.
